// File: rtl/image_writer.sv
`default_nettype none
// ============================================================================
// image_writer: packs raster-order R/G/B pixels into 24-bit frame-buffer writes.
// Optional BORDER_CLEAR_EN macro blanks border pixels.        Rev 1.0
// ============================================================================
module image_writer #(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int ADDR_W = 16,
   parameter int BORDER = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [7:0]        red_i,
   input  logic [7:0]        green_i,
   input  logic [7:0]        blue_i,
   input  logic              valid_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [23:0]       wr_data_o,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic              overflow_o
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W-1:0] addr;
   logic              accept;
   logic              last_pixel;
   logic              col_wrap;
   logic              overflow_set;
   logic              overflow_clr;
   logic [23:0]       pixel;

   assign col_wrap = (col == COL_LAST);

`ifdef BORDER_CLEAR_EN
   logic on_border;
   assign on_border = (int'(row) < BORDER) || (int'(row) >= IMG_H - BORDER) ||
                      (int'(col) < BORDER) || (int'(col) >= IMG_W - BORDER);
   assign pixel     = on_border ? 24'h000000 : {red_i, green_i, blue_i};
`else
   assign pixel     = {red_i, green_i, blue_i};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next   = state;
      accept       = 1'b0;
      last_pixel   = 1'b0;
      overflow_set = 1'b0;
      overflow_clr = 1'b0;
      case (state)
         IDLE: begin
            // start wins over a coincident pixel: the pixel is dropped silently
            if (start_i) begin
               state_next   = ACTIVE;
               overflow_clr = 1'b1;
            end else begin
               overflow_set = valid_i;
            end
         end
         ACTIVE: begin
            if (valid_i) begin
               accept = 1'b1;
               if (col_wrap && (row == ROW_LAST)) begin
                  last_pixel = 1'b1;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            overflow_set = valid_i;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         addr       <= '0;
         wr_en_o    <= 1'b0;
         wr_addr_o  <= '0;
         wr_data_o  <= '0;
         overflow_o <= 1'b0;
      end else begin
         wr_en_o <= accept;
         if (accept) begin
            wr_addr_o <= addr;
            wr_data_o <= pixel;
         end

         // running address avoids a row*IMG_W multiplier
         if (overflow_clr) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
         end else if (accept) begin
            if (col_wrap) begin
               col <= '0;
               row <= last_pixel ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            addr <= last_pixel ? '0 : addr + 1'b1;
         end

         if (overflow_clr)      overflow_o <= 1'b0;
         else if (overflow_set) overflow_o <= 1'b1;
      end
   end

   assign busy_o       = (state == ACTIVE);
   assign frame_done_o = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_image_writer.sv
`default_nettype none
// ============================================================================
// tb_image_writer: table-driven control checks plus a write scoreboard.  Rev 1.0
// ============================================================================
module tb_image_writer;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 3;
   localparam int ADDR_W = 4;
   localparam int NPIX   = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_i = 1'b0;
   logic [7:0]        red_i = '0;
   logic [7:0]        green_i = '0;
   logic [7:0]        blue_i = '0;
   logic              valid_i = 1'b0;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [23:0]       wr_data_o;
   logic              busy_o;
   logic              frame_done_o;
   logic              overflow_o;

   image_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .BORDER(1)) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .red_i(red_i), .green_i(green_i), .blue_i(blue_i), .valid_i(valid_i),
      .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .busy_o(busy_o), .frame_done_o(frame_done_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [23:0]       data;
      logic              done;
   } exp_t;

   typedef struct {
      logic start;
      logic valid;
      logic exp_busy;
      logic exp_ovf;
      logic exp_wr;
   } vec_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] exp_data(input int a, input logic [23:0] p);
`ifdef BORDER_CLEAR_EN
      int r = a / IMG_W;
      int c = a % IMG_W;
      if (r < 1 || r >= IMG_H - 1 || c < 1 || c >= IMG_W - 1) return 24'h000000;
`else
      if (a < 0) return 24'h000000;
`endif
      return p;
   endfunction

   // Drives one cycle of inputs; returns 1 time unit after the sampling edge.
   task automatic drive(input logic s, input logic v, input logic [23:0] p);
      start_i = s;
      valid_i = v;
      {red_i, green_i, blue_i} = p;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every write the DUT issues must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en_o) begin
            if (q.size() == 0) begin
               check("unexpected_write", {28'd0, wr_addr_o}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("sb_addr", {28'd0, wr_addr_o}, {28'd0, e.addr});
               check("sb_data", {8'd0, wr_data_o}, {8'd0, e.data});
               check("sb_done", {31'd0, frame_done_o}, {31'd0, e.done});
            end
         end else if (frame_done_o) begin
            check("done_without_write", 32'd1, 32'd0);
         end
      end
   end

   task automatic send_frame(input int gap, input bit ff);
      logic [23:0] p;
      exp_t        e;
      drive(1'b1, 1'b0, 24'h0);
      check("busy_after_start", {31'd0, busy_o}, 32'd1);
      check("ovf_after_start", {31'd0, overflow_o}, 32'd0);
      for (int i = 0; i < NPIX; i++) begin
         p = ff ? 24'hFFFFFF : {8'(i), 8'(i + 8'h40), 8'(i + 8'h80)};
         e.addr = ADDR_W'(i);
         e.data = exp_data(i, p);
         e.done = (i == NPIX - 1);
         q.push_back(e);
         drive(1'b0, 1'b1, p);
         check("wr_en_latency", {31'd0, wr_en_o}, 32'd1);
         check("busy_in_frame", {31'd0, busy_o}, (i == NPIX - 1) ? 32'd0 : 32'd1);
         if (i < NPIX - 1) begin
            for (int g = 0; g < gap; g++) begin
               drive(1'b0, 1'b0, 24'hABCDEF);
               check("gap_wr_en", {31'd0, wr_en_o}, 32'd0);
               check("gap_hold_addr", {28'd0, wr_addr_o}, i);
               check("gap_hold_data", {8'd0, wr_data_o}, {8'd0, exp_data(i, p)});
            end
         end
      end
      // DONE cycle: pixel dropped, overflow set, start ignored
      drive(1'b1, 1'b1, 24'h555555);
      check("done_wr_en", {31'd0, wr_en_o}, 32'd0);
      check("done_ovf", {31'd0, overflow_o}, 32'd1);
      check("done_busy", {31'd0, busy_o}, 32'd0);
      drive(1'b0, 1'b0, 24'h0);
      check("idle_busy", {31'd0, busy_o}, 32'd0);
      check("idle_ovf_sticky", {31'd0, overflow_o}, 32'd1);
      check("sb_empty", q.size(), 32'd0);
   endtask

   vec_t vecs[6];
   int   pn;

   initial begin
      // start, valid -> busy, overflow, wr_en (one row per cycle, from IDLE)
      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      // reset held with valid toggling
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, i[0], 24'h123456);
         check("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
         check("rst_addr", {28'd0, wr_addr_o}, 32'd0);
         check("rst_busy", {31'd0, busy_o}, 32'd0);
         check("rst_ovf", {31'd0, overflow_o}, 32'd0);
         check("rst_done", {31'd0, frame_done_o}, 32'd0);
      end
      rst = 1'b0;

      pn = 0;
      for (int i = 0; i < 6; i++) begin
         exp_t e;
         if (vecs[i].exp_wr) begin
            e.addr = ADDR_W'(pn);
            e.data = exp_data(pn, {3{8'(pn)}});
            e.done = 1'b0;
            q.push_back(e);
         end
         drive(vecs[i].start, vecs[i].valid, {3{8'(pn)}});
         if (vecs[i].exp_wr) pn++;
         check($sformatf("vec%0d_busy", i), {31'd0, busy_o}, {31'd0, vecs[i].exp_busy});
         check($sformatf("vec%0d_ovf", i), {31'd0, overflow_o}, {31'd0, vecs[i].exp_ovf});
         check($sformatf("vec%0d_wr_en", i), {31'd0, wr_en_o}, {31'd0, vecs[i].exp_wr});
      end

      // three more pixels, then reset with the fifth write in flight
      while (pn < 5) begin
         exp_t e;
         e.addr = ADDR_W'(pn);
         e.data = exp_data(pn, {3{8'(pn)}});
         e.done = 1'b0;
         if (pn < 4) q.push_back(e);
         drive(1'b0, 1'b1, {3{8'(pn)}});
         pn++;
      end
      check("pre_rst_wr_en", {31'd0, wr_en_o}, 32'd1);
      valid_i = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("midrst_wr_en", {31'd0, wr_en_o}, 32'd0);
      check("midrst_done", {31'd0, frame_done_o}, 32'd0);
      check("midrst_busy", {31'd0, busy_o}, 32'd0);
      check("midrst_sb", q.size(), 32'd0);
      q.delete();
      drive(1'b0, 1'b0, 24'h0);
      rst = 1'b0;
      check("post_rst_done", {31'd0, frame_done_o}, 32'd0);

      send_frame(0, 1'b0);
      send_frame(2, 1'b0);
      send_frame(0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
